// File: rtl/hamming_channel_tx.sv
// Serial line framer for Hamming codewords: start bit, data LSB-first, stop bit, idle gap.
// Optional channel error injection is compiled in when HAMMING_ERR_INJECT_EN is defined.
module hamming_channel_tx #(
    parameter int CW_WIDTH   = 16,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CW_WIDTH-1:0]          cw_in,
    input  logic                         cw_valid,
    output logic                         cw_ready,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic                         err_en,
    input  logic [$clog2(CW_WIDTH)-1:0]  err_pos,
    output logic [CNT_WIDTH-1:0]         errs_injected,
`endif
    output logic                         tx_bit,
    output logic                         tx_start,
    output logic                         tx_frame,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         frames_sent
);

    // Handshake: a codeword transfers on the rising edge where cw_valid && cw_ready;
    // cw_ready is high only in IDLE and inputs are ignored in every other state.

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int BIT_W = $clog2(CW_WIDTH);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CW_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [2:0]           state_q,   state_d;
    logic [CW_WIDTH-1:0]  shreg_q,   shreg_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0] frames_q,  frames_d;
    logic [CW_WIDTH-1:0]  load_word;
    logic                 accept;
    logic                 stop_exit;

`ifdef HAMMING_ERR_INJECT_EN
    localparam int POS_W = $clog2(CW_WIDTH);
    logic                 flip_q, flip_d;
    logic                 flip_hit;
    logic [CNT_WIDTH-1:0] errs_q, errs_d;

    // Positions at or beyond CW_WIDTH never match, so they leave the word untouched.
    always_comb begin
        load_word = cw_in;
        flip_hit  = 1'b0;
        for (int i = 0; i < CW_WIDTH; i++) begin
            if (err_en && (err_pos == POS_W'(i))) begin
                load_word[i] = ~cw_in[i];
                flip_hit     = 1'b1;
            end
        end
    end
`else
    assign load_word = cw_in;
`endif

    assign accept    = (state_q == S_IDLE) && cw_valid;
    assign stop_exit = (state_q == S_STOP);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        frames_d  = frames_q;
        case (state_q)
            S_IDLE: begin
                if (cw_valid) begin
                    shreg_d   = load_word;
                    bit_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: state_d = S_DATA;
            S_DATA: begin
                shreg_d   = shreg_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                frames_d  = frames_q + 1'b1;
                gap_cnt_d = '0;
                state_d   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef HAMMING_ERR_INJECT_EN
    always_comb begin
        flip_d = flip_q;
        errs_d = errs_q;
        if (accept) flip_d = flip_hit;
        if (stop_exit && flip_q) errs_d = errs_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flip_q <= 1'b0;
            errs_q <= '0;
        end else begin
            flip_q <= flip_d;
            errs_q <= errs_d;
        end
    end

    assign errs_injected = errs_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            frames_q  <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            frames_q  <= frames_d;
        end
    end

    // Line outputs decode from state so an asynchronous reset forces the line high at once.
    always_comb begin
        tx_bit   = 1'b1;
        tx_start = 1'b0;
        tx_frame = 1'b0;
        case (state_q)
            S_START: begin
                tx_bit   = 1'b0;
                tx_start = 1'b1;
            end
            S_DATA: begin
                tx_bit   = shreg_q[0];
                tx_frame = 1'b1;
            end
            default: tx_bit = 1'b1;
        endcase
    end

    assign cw_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_hamming_channel_tx.sv
// Bench for hamming_channel_tx: vector table, directed corner sequences and random traffic
// checked cycle by cycle against a frame-level reference model.
module tb_hamming_channel_tx;

  localparam int CW     = 16;
  localparam int GAP    = 2;
  localparam int CNT    = 16;
  localparam int PERIOD = 1 + CW + 1 + GAP;
  localparam int NV     = 5;

  logic            clk;
  logic            rst_n;
  logic [CW-1:0]   cw_in;
  logic            cw_valid;
  logic            cw_ready;
  logic            tx_bit;
  logic            tx_start;
  logic            tx_frame;
  logic            busy;
  logic [CNT-1:0]  frames_sent;
`ifdef HAMMING_ERR_INJECT_EN
  logic            err_en;
  logic [3:0]      err_pos;
  logic [CNT-1:0]  errs_injected;
`endif

  hamming_channel_tx #(.CW_WIDTH(CW), .GAP_CYCLES(GAP), .CNT_WIDTH(CNT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cw_in(cw_in),
    .cw_valid(cw_valid),
    .cw_ready(cw_ready),
`ifdef HAMMING_ERR_INJECT_EN
    .err_en(err_en),
    .err_pos(err_pos),
    .errs_injected(errs_injected),
`endif
    .tx_bit(tx_bit),
    .tx_start(tx_start),
    .tx_frame(tx_frame),
    .busy(busy),
    .frames_sent(frames_sent)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: the whole expected line for the frame in flight
  int            m_left;
  logic          m_line[PERIOD];
  int            m_frames;
  int            m_errs;
  logic          m_flip;
  logic [CW-1:0] exp_q[$];

  // observation state
  logic [CW-1:0] rx_word;
  int            rx_n;
  int            cyc_n;
  logic          cap_en;
  logic [17:0]   cap_bits;
  int            cap_n;
  int            frame_hi_cnt;
  int            ready_low_cnt;
  int            last_start;
  int            start_gap;

  typedef struct {
    logic [CW-1:0] cw;
    logic [17:0]   line;
  } vec_t;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    m_left   = 0;
    m_frames = 0;
    m_errs   = 0;
    m_flip   = 1'b0;
    rx_n     = 0;
    exp_q.delete();
  endtask

  task automatic model_accept();
    logic [CW-1:0] w;
    w      = cw_in;
    m_flip = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
    if (err_en && int'(err_pos) < CW) begin
      w[err_pos] = ~w[err_pos];
      m_flip     = 1'b1;
    end
`endif
    m_line[0] = 1'b0;
    for (int i = 0; i < CW; i++) m_line[1 + i] = w[i];
    m_line[CW + 1] = 1'b1;
    for (int g = 0; g < GAP; g++) m_line[CW + 2 + g] = 1'b1;
    exp_q.push_back(w);
    m_left = PERIOD;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cyc();
    int   pos;
    logic e_tx;
    @(negedge clk);
    pos  = PERIOD - m_left;
    e_tx = (m_left == 0) ? 1'b1 : m_line[pos];
    check("cw_ready", cw_ready, m_left == 0);
    check("busy", busy, m_left != 0);
    check("tx_bit", tx_bit, e_tx);
    check("tx_start", tx_start, (m_left != 0) && (pos == 0));
    check("tx_frame", tx_frame, (m_left != 0) && (pos >= 1) && (pos <= CW));
    check("frames_sent", frames_sent, CNT'(m_frames));
`ifdef HAMMING_ERR_INJECT_EN
    check("errs_injected", errs_injected, CNT'(m_errs));
`endif
    // scoreboard: rebuild each codeword off the line
    if (tx_start) rx_n = 0;
    if (tx_frame) begin
      rx_word = {tx_bit, rx_word[CW-1:1]};
      rx_n++;
      if (rx_n == CW) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL frame_data: got %0h with no frame expected", rx_word);
        end else begin
          check("frame_data", rx_word, exp_q.pop_front());
        end
      end
    end
    if (cap_en && cap_n < 18) begin
      cap_bits[cap_n] = tx_bit;
      cap_n++;
    end
    if (tx_frame) frame_hi_cnt++;
    if (!cw_ready) ready_low_cnt++;
    if (tx_start) begin
      start_gap  = cyc_n - last_start;
      last_start = cyc_n;
    end
    @(posedge clk);
    cyc_n++;
    if (!rst_n) begin
      model_reset();
    end else if (m_left == 0) begin
      if (cw_valid) model_accept();
    end else begin
      if (pos == CW + 1) begin
        m_frames++;
        if (m_flip) m_errs++;
      end
      m_left--;
    end
    #1;
  endtask

  // driver: wait for idle, present one codeword for one cycle, capture the line
  task automatic send_frame(input logic [CW-1:0] w, output logic [17:0] line, output int hi);
    int guard;
    guard = 0;
    while (m_left != 0 && guard < 100) begin
      cyc();
      guard++;
    end
    if (guard >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy expected idle within 100 cycles");
    end
    cw_in    = w;
    cw_valid = 1'b1;
    cyc();
    cw_valid     = 1'b0;
    cap_en       = 1'b1;
    cap_n        = 0;
    frame_hi_cnt = 0;
    repeat (PERIOD) cyc();
    cap_en = 1'b0;
    line   = cap_bits;
    hi     = frame_hi_cnt;
  endtask

  initial begin
    logic [17:0] line;
    int          hi;

    vecs[0] = '{cw: 16'hA5C3, line: 18'h34B86};
    vecs[1] = '{cw: 16'h0000, line: 18'h20000};
    vecs[2] = '{cw: 16'hFFFF, line: 18'h3FFFE};
    vecs[3] = '{cw: 16'h1234, line: 18'h22468};
    vecs[4] = '{cw: 16'h8001, line: 18'h30002};

    rst_n    = 1'b0;
    cw_in    = '0;
    cw_valid = 1'b0;
    cap_en   = 1'b0;
    cap_n    = 0;
    cyc_n    = 0;
    last_start    = 0;
    start_gap     = 0;
    ready_low_cnt = 0;
    frame_hi_cnt  = 0;
    rx_word  = '0;
`ifdef HAMMING_ERR_INJECT_EN
    err_en  = 1'b0;
    err_pos = '0;
`endif
    model_reset();

    // reset state, then idle with no traffic
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    check("idle_tx_bit", tx_bit, 1'b1);
    check("idle_ready", cw_ready, 1'b1);
    check("idle_frames", frames_sent, 0);

    // table-driven single frames
    for (int i = 0; i < NV; i++) begin
      send_frame(vecs[i].cw, line, hi);
      check($sformatf("vec%0d_line", i), line, vecs[i].line);
      check($sformatf("vec%0d_frame_cycles", i), hi, CW);
      check($sformatf("vec%0d_frames", i), frames_sent, i + 1);
    end

    // back-to-back with cw_valid held; cw_in changes mid-frame are ignored
    cw_in    = 16'h0001;
    cw_valid = 1'b1;
    cyc();
    cw_in         = 16'hFFFF;
    ready_low_cnt = 0;
    repeat (PERIOD + 1) cyc();
    check("ready_low_cycles", ready_low_cnt, PERIOD);
    cyc();
    check("start_spacing", start_gap, PERIOD + 1);
    repeat (5) cyc();
    cw_in = 16'h0000;
    repeat (PERIOD - 6) cyc();
    check("b2b_frames", frames_sent, NV + 2);
    check("b2b_ready_again", cw_ready, 1'b1);
    cyc();
    cw_valid = 1'b0;
    repeat (PERIOD) cyc();
    check("late_word_frames", frames_sent, NV + 3);

    // asynchronous reset in the middle of data bit 7
    cw_in    = 16'hFFFF;
    cw_valid = 1'b1;
    cyc();
    cw_valid = 1'b0;
    repeat (8) cyc();
    check("pre_reset_frame", tx_frame, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_tx_bit", tx_bit, 1'b1);
    check("rst_frames", frames_sent, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", cw_ready, 1'b1);
    model_reset();
    repeat (2) cyc();
    rst_n = 1'b1;
    send_frame(16'h1234, line, hi);
    check("post_rst_line", line, 18'h22468);
    check("post_rst_frames", frames_sent, 1);

`ifdef HAMMING_ERR_INJECT_EN
    err_en  = 1'b1;
    err_pos = 4'd2;
    send_frame(16'h0000, line, hi);
    check("inject_line", line, 18'h20008);
    check("inject_count", errs_injected, 1);
    err_en = 1'b0;
    send_frame(16'h0000, line, hi);
    check("noinject_line", line, 18'h20000);
    check("noinject_count", errs_injected, 1);
`endif

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cw_valid = ($urandom_range(0, 2) == 0);
      cw_in    = CW'($urandom);
`ifdef HAMMING_ERR_INJECT_EN
      err_en  = $urandom_range(0, 1) == 1;
      err_pos = 4'($urandom);
`endif
      cyc();
    end
    cw_valid = 1'b0;
    repeat (PERIOD + 2) cyc();
    check("drain_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
